// File: rtl/jtag_ir_dr_controller.sv
// JTAG instruction/data register block driven by an external TAP state.
// Holds the IR, IDCODE, USER and BYPASS scan chains and the serial output.
module jtag_ir_dr_controller #(
    parameter logic [31:0] IDCODE     = 32'h0000_FAF0,
    parameter int unsigned USER_WIDTH = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tdi,
    input  logic [4:0]            tap_state,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [3:0]            ir,
    output logic [USER_WIDTH-1:0] user_data,
    output logic                  user_update,
    output logic [5:0]            bit_count
);

    localparam logic [4:0] StTestLogicReset = 5'h00;
    localparam logic [4:0] StCaptureDr      = 5'h04;
    localparam logic [4:0] StCaptureIr      = 5'h05;
    localparam logic [4:0] StShiftDr        = 5'h06;
    localparam logic [4:0] StShiftIr        = 5'h07;
    localparam logic [4:0] StUpdateDr       = 5'h14;
    localparam logic [4:0] StUpdateIr       = 5'h15;

    localparam logic [3:0] InstrIdcode = 4'h1;
    localparam logic [3:0] InstrUser   = 4'h8;

    // Data register chosen at CaptureDr; a later IR update cannot re-target the scan.
    typedef enum logic [1:0] {SelId, SelUser, SelBypass} dr_sel_e;

    logic                  tdo_q, tdo_d;
    logic                  tdo_en_q, tdo_en_d;
    logic [3:0]            ir_q, ir_d;
    logic [USER_WIDTH-1:0] user_data_q, user_data_d;
    logic                  user_update_q, user_update_d;
    logic [5:0]            bit_count_q, bit_count_d;
    logic [3:0]            ir_shift_q, ir_shift_d;
    logic [31:0]           id_shift_q, id_shift_d;
    logic [USER_WIDTH-1:0] user_shift_q, user_shift_d;
    logic                  bypass_q, bypass_d;
    dr_sel_e               dr_sel_q, dr_sel_d;
    dr_sel_e               ir_sel;
    logic [5:0]            bit_count_inc;

    // Decode the active instruction; unknown codes fall back to BYPASS.
    always_comb begin
        ir_sel        = SelBypass;
        bit_count_inc = (bit_count_q == 6'd63) ? bit_count_q : bit_count_q + 6'd1;
        if (ir_q == InstrIdcode) begin
            ir_sel = SelId;
        end else if (ir_q == InstrUser) begin
            ir_sel = SelUser;
        end
    end

    // Next-state for every register as a function of the current TAP state.
    always_comb begin
        tdo_d         = tdo_q;
        tdo_en_d      = 1'b0;
        ir_d          = ir_q;
        user_data_d   = user_data_q;
        user_update_d = 1'b0;
        bit_count_d   = bit_count_q;
        ir_shift_d    = ir_shift_q;
        id_shift_d    = id_shift_q;
        user_shift_d  = user_shift_q;
        bypass_d      = bypass_q;
        dr_sel_d      = dr_sel_q;

        case (tap_state)
            StTestLogicReset: begin
                ir_d        = InstrIdcode;
                ir_shift_d  = 4'h0;
                bit_count_d = 6'd0;
                dr_sel_d    = SelId;
            end
            StCaptureIr: begin
                ir_shift_d  = 4'b0101;
                bit_count_d = 6'd0;
            end
            StShiftIr: begin
                tdo_d       = ir_shift_q[0];
                ir_shift_d  = {tdi, ir_shift_q[3:1]};
                tdo_en_d    = 1'b1;
                bit_count_d = bit_count_inc;
            end
            StUpdateIr: begin
                ir_d = ir_shift_q;
            end
            StCaptureDr: begin
                bit_count_d = 6'd0;
                dr_sel_d    = ir_sel;
                case (ir_sel)
                    SelId:   id_shift_d   = IDCODE;
                    SelUser: user_shift_d = user_capture_data;
                    default: bypass_d     = 1'b0;
                endcase
            end
            StShiftDr: begin
                tdo_en_d    = 1'b1;
                bit_count_d = bit_count_inc;
                case (dr_sel_q)
                    SelId: begin
                        tdo_d      = id_shift_q[0];
                        id_shift_d = {tdi, id_shift_q[31:1]};
                    end
                    SelUser: begin
                        tdo_d        = user_shift_q[0];
                        user_shift_d = {tdi, user_shift_q[USER_WIDTH-1:1]};
                    end
                    default: begin
                        tdo_d    = bypass_q;
                        bypass_d = tdi;
                    end
                endcase
            end
            StUpdateDr: begin
                if (ir_q == InstrUser) begin
                    user_data_d   = user_shift_q;
                    user_update_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register; trst overrides whatever the TAP state requests.
    always_ff @(posedge tck) begin
        if (trst) begin
            tdo_q         <= 1'b0;
            tdo_en_q      <= 1'b0;
            ir_q          <= InstrIdcode;
            user_data_q   <= '0;
            user_update_q <= 1'b0;
            bit_count_q   <= 6'd0;
            ir_shift_q    <= 4'h0;
            id_shift_q    <= 32'h0;
            user_shift_q  <= '0;
            bypass_q      <= 1'b0;
            dr_sel_q      <= SelId;
        end else begin
            tdo_q         <= tdo_d;
            tdo_en_q      <= tdo_en_d;
            ir_q          <= ir_d;
            user_data_q   <= user_data_d;
            user_update_q <= user_update_d;
            bit_count_q   <= bit_count_d;
            ir_shift_q    <= ir_shift_d;
            id_shift_q    <= id_shift_d;
            user_shift_q  <= user_shift_d;
            bypass_q      <= bypass_d;
            dr_sel_q      <= dr_sel_d;
        end
    end

    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign ir          = ir_q;
    assign user_data   = user_data_q;
    assign user_update = user_update_q;
    assign bit_count   = bit_count_q;

endmodule

// File: doc/jtag_ir_dr_controller.md
JTAG_IR_DR_CONTROLLER -- requirements
Module: jtag_ir_dr_controller

Interface
REQ-001 Parameter IDCODE, default 32'h0000_FAF0: device identification value loaded in CaptureDr when IR selects IDCODE.
REQ-002 Parameter USER_WIDTH, default 8: width of the user data register.
REQ-003 The block SHALL have one clock, tck; reset trst is synchronous and active-high.
REQ-004 tck  input  1  TAP clock; all state changes on rising edge.
REQ-005 trst  input  1  synchronous active-high reset.
REQ-006 tdi  input  1  serial scan input.
REQ-007 tap_state  input  5  current TAP state, team encoding: TestLogicReset=5'h00, CaptureDr=5'h04, CaptureIr=5'h05, ShiftDr=5'h06, ShiftIr=5'h07, UpdateDr=5'h14, UpdateIr=5'h15.
REQ-008 user_capture_data  input  USER_WIDTH  parallel value sampled into the USER register at CaptureDr.
REQ-009 tdo  output  1  registered serial scan output.
REQ-010 tdo_en  output  1  high for the cycle after every Shift-state edge.
REQ-011 ir  output  4  active instruction.
REQ-012 user_data  output  USER_WIDTH  last value committed to the USER register.
REQ-013 user_update  output  1  one-cycle strobe when user_data is written.
REQ-014 bit_count  output  6  bits shifted since the last Capture, saturating.

Function
REQ-015 Instructions SHALL be IDCODE=4'h1, USER=4'h8, BYPASS=4'hF; every other code SHALL behave as BYPASS.
REQ-016 Internal registers: ir_shift[3:0], id_shift[31:0], user_shift[USER_WIDTH-1:0], bypass_bit.
REQ-017 tap_state=TestLogicReset SHALL set ir<=4'h1, ir_shift<=0, bit_count<=0, tdo_en<=0; user_data SHALL be unchanged.
REQ-018 CaptureIr SHALL load ir_shift<=4'b0101 and bit_count<=0.
REQ-019 ShiftIr SHALL perform ir_shift<={tdi, ir_shift[3:1]}, tdo<=old ir_shift[0], tdo_en<=1.
REQ-020 UpdateIr SHALL load ir<=ir_shift.
REQ-021 CaptureDr SHALL load bit_count<=0 and only the register selected by ir: id_shift<=IDCODE, user_shift<=user_capture_data, or bypass_bit<=0.
REQ-022 ShiftDr SHALL right-shift only the selected register with tdi entering the MSB (bypass_bit<=tdi), tdo<=old LSB, tdo_en<=1.
REQ-023 UpdateDr with ir=USER SHALL load user_data<=user_shift and pulse user_update for exactly one cycle; UpdateDr with any other ir SHALL have no effect.
REQ-024 bit_count SHALL increment once per Shift cycle and saturate at 63 (no wrap).
REQ-025 In every non-Shift state, tdo_en SHALL be 0 and tdo SHALL hold its last value.
REQ-026 Unlisted tap_state values (including 5'h0A-5'h0F, 5'h16-5'h1F) SHALL be no-ops: no register changes, tdo_en=0, user_update=0.
REQ-027 An IR change SHALL take effect for the next CaptureDr only; a DR scan in progress SHALL NOT be re-targeted.
REQ-028 Shifting past register length SHALL continue shifting; tdo SHALL emit the tdi bits delayed by the register length.

Reset
REQ-029 trst=1 at a tck edge SHALL set tdo=0, tdo_en=0, ir=4'h1, user_data=0, user_update=0, bit_count=0, ir_shift=0, id_shift=0, user_shift=0, bypass_bit=0, overriding tap_state.
REQ-030 trst asserted mid-shift SHALL abort the scan; no Update SHALL result from the partial scan.

Verification
REQ-031 trst, CaptureDr, 32x ShiftDr tdi=0 -> tdo bits (one cycle later, LSB first) 0,0,0,0,1,1,1,1,0,1,0,1,1,1,1,1 then 16x 0; bit_count=32.
REQ-032 CaptureIr, 4x ShiftIr tdi=0,0,0,1, UpdateIr -> tdo 1,0,1,0; ir=4'h8.
REQ-033 ir=8, user_capture_data=8'hA5, CaptureDr, 8x ShiftDr tdi=LSB-first 8'h3C, UpdateDr -> tdo LSB-first 8'hA5; user_data=8'h3C; user_update high one cycle.
REQ-034 ir=4'h3 (unknown), CaptureDr, 3x ShiftDr tdi=1,0,1 -> tdo 0,1,0 (one-bit bypass).
REQ-035 ir=8, 4x ShiftDr then trst, then UpdateDr -> user_data=0, user_update never high; ir=4'h1.
REQ-036 70x ShiftDr -> bit_count holds 63; tap_state=5'h1F -> all registers unchanged.
